bldcm_ramp_commutator: RTL and testbench

Parametrised, multi-channel successor to the single-motor BLDC drive path. It generates the 6-step commutation phase for pNumCh independent motors. Each channel has a soft-start / soft-stop frequency ramp: the commutation divider slews toward its target in fixed steps instead of jumping. It sits between the register interface and per-channel PWM/dead-time output stages, and replaces the fixed-divider phase stepping.

---
 rtl/bldcm_ramp_commutator.sv | 153 +++++++++++++++
 tb/tb_bldcm_ramp_commutator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldcm_ramp_commutator.sv
// Multi-channel 6-step BLDC commutator with per-channel soft-start/soft-stop divider ramp.
// Shared ramp prescaler and step size; each channel runs its own FSM and phase counter.
module bldcm_ramp_commutator #(
   parameter int unsigned          pNumCh      = 2,
   parameter int unsigned          pDivWidth   = 32,
   parameter int unsigned          pStepWidth  = 16,
   parameter logic [pDivWidth-1:0] pDivStart   = pDivWidth'(100000),
   parameter logic [pDivWidth-1:0] pDivMin     = pDivWidth'(1000),
   parameter int unsigned          pRampPeriod = 50000
) (
   input  logic                          iClock,
   input  logic                          iReset_n,
   input  logic [pNumCh-1:0]             iLatch,
   input  logic [pNumCh*pDivWidth-1:0]   iDivTarget,
   input  logic [pNumCh-1:0]             iDir,
   input  logic [pNumCh-1:0]             iRun,
   input  logic [pStepWidth-1:0]         iRampStep,
   output logic [pNumCh*3-1:0]           oPhase,
   output logic [pNumCh-1:0]             oPhaseTick,
   output logic [pNumCh*pDivWidth-1:0]   oDivCur,
   output logic [pNumCh-1:0]             oRunning,
   output logic [pNumCh-1:0]             oAtTarget
);

   localparam int unsigned W     = pDivWidth;
   localparam int unsigned W1    = pDivWidth + 1;
   localparam int unsigned PRE_W = (pRampPeriod > 1) ? $clog2(pRampPeriod) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(pRampPeriod - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_CRUISE, ST_STOPPING} state_t;

   // Move cur toward dst by step, landing exactly on dst; a zero step jumps straight there.
   function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                input logic [W-1:0] dst,
                                                input logic [pStepWidth-1:0] step);
      logic [W1-1:0] step_ext;
      logic [W1-1:0] gap;
      step_ext = W1'(step);
      gap      = (cur > dst) ? W1'(cur - dst) : W1'(dst - cur);
      if (step == '0 || step_ext >= gap) return dst;
      return (cur > dst) ? cur - W'(step) : cur + W'(step);
   endfunction

   // Zero is kept as the stop request; everything else is forced into the legal range.
   function automatic logic [W-1:0] clamp_target(input logic [W-1:0] raw);
      if (raw == '0) return '0;
      if (raw < pDivMin) return pDivMin;
      if (raw > pDivStart) return pDivStart;
      return raw;
   endfunction

   logic [PRE_W-1:0] pre_cnt;
   logic             ramp_tick;

   assign ramp_tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge iClock) begin
      if (!iReset_n)      pre_cnt <= '0;
      else if (ramp_tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + PRE_W'(1);
   end

   for (genvar i = 0; i < pNumCh; i++) begin : g_ch
      state_t         state;
      state_t         state_nxt;
      logic [W-1:0]   target;
      logic [W-1:0]   div_cur;
      logic [W-1:0]   div_nxt;
      logic [W-1:0]   cnt;
      logic [2:0]     phase;
      logic           dir_pend;
      logic           dir_act;
      logic           phase_tick;
      logic           running;
      logic           at_target;
      logic           run_ok;
      logic           wrap;

      assign run_ok = iRun[i] && (target != '0);
      assign wrap   = (cnt >= div_cur - W'(1));

      always_comb begin
         state_nxt = state;
         div_nxt   = div_cur;
         case (state)
            ST_IDLE: begin
               div_nxt = pDivStart;
               if (run_ok) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
               if (!run_ok)                state_nxt = ST_STOPPING;
               else if (div_cur == target) state_nxt = ST_CRUISE;
               else if (ramp_tick)         div_nxt   = step_toward(div_cur, target, iRampStep);
            end
            ST_CRUISE: begin
               if (!run_ok)                state_nxt = ST_STOPPING;
               else if (target != div_cur) state_nxt = ST_RAMP;
            end
            ST_STOPPING: begin
               if (run_ok)                    state_nxt = ST_RAMP;
               else if (div_cur == pDivStart) state_nxt = ST_IDLE;
               else if (ramp_tick)            div_nxt   = step_toward(div_cur, pDivStart, iRampStep);
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      always_ff @(posedge iClock) begin
         if (!iReset_n) begin
            state      <= ST_IDLE;
            target     <= pDivStart;
            dir_pend   <= 1'b0;
            dir_act    <= 1'b0;
            div_cur    <= pDivStart;
            cnt        <= '0;
            phase      <= 3'd0;
            phase_tick <= 1'b0;
            running    <= 1'b0;
            at_target  <= 1'b0;
         end else begin
            state     <= state_nxt;
            div_cur   <= div_nxt;
            running   <= (state_nxt != ST_IDLE);
            at_target <= (state_nxt == ST_CRUISE);
            if (iLatch[i]) begin
               target   <= clamp_target(iDivTarget[i*W +: W]);
               dir_pend <= iDir[i];
            end
            // Direction only changes while stopped, on the way out of IDLE.
            if (state == ST_IDLE) begin
               cnt        <= '0;
               phase_tick <= 1'b0;
               if (state_nxt == ST_RAMP) dir_act <= dir_pend;
            end else if (wrap) begin
               cnt        <= '0;
               phase_tick <= 1'b1;
               if (dir_act) phase <= (phase == 3'd0) ? 3'd5 : phase - 3'd1;
               else         phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
            end else begin
               cnt        <= cnt + W'(1);
               phase_tick <= 1'b0;
            end
         end
      end

      assign oPhase[i*3 +: 3] = phase;
      assign oPhaseTick[i]    = phase_tick;
      assign oDivCur[i*W +: W] = div_cur;
      assign oRunning[i]      = running;
      assign oAtTarget[i]     = at_target;
   end

endmodule

// File: tb/tb_bldcm_ramp_commutator.sv
// Bench for bldcm_ramp_commutator: directed scenarios then random traffic,
// every cycle compared against a cycle-level behavioural model of the channel rules.
module tb_bldcm_ramp_commutator;

   localparam int NCH    = 2;
   localparam int DW     = 32;
   localparam int SW     = 16;
   localparam int DSTART = 100;
   localparam int DMIN   = 10;
   localparam int RPER   = 4;

   localparam int MI = 0;   // stopped
   localparam int MR = 1;   // slewing to target
   localparam int MC = 2;   // holding target
   localparam int MS = 3;   // slewing back to start speed

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    latch;
   logic [NCH*DW-1:0] div_target;
   logic [NCH-1:0]    dir;
   logic [NCH-1:0]    run;
   logic [SW-1:0]     ramp_step;
   logic [NCH*3-1:0]  o_phase;
   logic [NCH-1:0]    o_tick;
   logic [NCH*DW-1:0] o_div;
   logic [NCH-1:0]    o_running;
   logic [NCH-1:0]    o_at;

   int n_cmp;
   int n_err;

   int m_pre;
   int m_mode[NCH];
   int m_tgt[NCH];
   int m_pend[NCH];
   int m_dir[NCH];
   int m_div[NCH];
   int m_cnt[NCH];
   int m_phase[NCH];
   int m_ptick[NCH];

   bldcm_ramp_commutator #(
      .pNumCh(NCH), .pDivWidth(DW), .pStepWidth(SW),
      .pDivStart(32'd100), .pDivMin(32'd10), .pRampPeriod(32'd4)
   ) dut (
      .iClock(clk), .iReset_n(rst_n), .iLatch(latch), .iDivTarget(div_target),
      .iDir(dir), .iRun(run), .iRampStep(ramp_step),
      .oPhase(o_phase), .oPhaseTick(o_tick), .oDivCur(o_div),
      .oRunning(o_running), .oAtTarget(o_at)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int toward(input int d, input int t, input int s);
      if (s == 0) return t;
      if (d > t)  return (d - s < t) ? t : d - s;
      return (d + s > t) ? t : d + s;
   endfunction

   function automatic int clamp(input longint raw);
      if (raw == 0)      return 0;
      if (raw < DMIN)    return DMIN;
      if (raw > DSTART)  return DSTART;
      return int'(raw);
   endfunction

   // One clock of the reference: inputs as seen at the edge, state before the edge.
   task automatic model_update();
      bit tick;
      bit ok;
      if (!rst_n) begin
         m_pre = 0;
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = MI; m_tgt[c] = DSTART; m_pend[c] = 0; m_dir[c] = 0;
            m_div[c] = DSTART; m_cnt[c] = 0; m_phase[c] = 0; m_ptick[c] = 0;
         end
      end else begin
         tick  = (m_pre == RPER - 1);
         m_pre = tick ? 0 : m_pre + 1;
         for (int c = 0; c < NCH; c++) begin
            ok = run[c] && (m_tgt[c] != 0);
            if (m_mode[c] == MI) begin
               m_cnt[c] = 0; m_ptick[c] = 0;
            end else if (m_cnt[c] + 1 >= m_div[c]) begin
               m_cnt[c]   = 0;
               m_ptick[c] = 1;
               m_phase[c] = m_dir[c] ? (m_phase[c] + 5) % 6 : (m_phase[c] + 1) % 6;
            end else begin
               m_cnt[c]++; m_ptick[c] = 0;
            end
            case (m_mode[c])
               MI: begin
                  m_div[c] = DSTART;
                  if (ok) begin m_mode[c] = MR; m_dir[c] = m_pend[c]; end
               end
               MR: begin
                  if (!ok)                        m_mode[c] = MS;
                  else if (m_div[c] == m_tgt[c])  m_mode[c] = MC;
                  else if (tick)                  m_div[c] = toward(m_div[c], m_tgt[c], int'(ramp_step));
               end
               MC: begin
                  if (!ok)                        m_mode[c] = MS;
                  else if (m_tgt[c] != m_div[c])  m_mode[c] = MR;
               end
               default: begin
                  if (ok)                         m_mode[c] = MR;
                  else if (m_div[c] == DSTART)    m_mode[c] = MI;
                  else if (tick)                  m_div[c] = toward(m_div[c], DSTART, int'(ramp_step));
               end
            endcase
            if (latch[c]) begin
               m_tgt[c]  = clamp(longint'(div_target[c*DW +: DW]));
               m_pend[c] = int'(dir[c]);
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("phase_ch%0d", c),   32'(o_phase[c*3 +: 3]),  32'(m_phase[c]));
         chk($sformatf("tick_ch%0d", c),    32'(o_tick[c]),          32'(m_ptick[c]));
         chk($sformatf("div_ch%0d", c),     o_div[c*DW +: DW],       32'(m_div[c]));
         chk($sformatf("running_ch%0d", c), 32'(o_running[c]),       32'(m_mode[c] != MI));
         chk($sformatf("at_ch%0d", c),      32'(o_at[c]),            32'(m_mode[c] == MC));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   function automatic logic pick(input int sel, input int c);
      case (sel)
         0:       return o_running[c];
         1:       return o_at[c];
         default: return o_tick[c];
      endcase
   endfunction

   // sel: 0=running 1=at_target 2=phase tick; an expired bound shows up as a failed check.
   task automatic wait_bit(input string tag, input int sel, input int c, input logic val, input int bound);
      int k = 0;
      do begin step(); k++; end while (pick(sel, c) !== val && k < bound);
      chk(tag, 32'(pick(sel, c)), 32'(val));
   endtask

   task automatic wait_div_change(input string tag, input int c, input int bound);
      int k = 0;
      do begin step(); k++; end while (o_div[c*DW +: DW] === 32'(DSTART) && k < bound);
      chk(tag, 32'(o_div[c*DW +: DW] !== 32'(DSTART)), 32'd1);
   endtask

   task automatic do_latch(input int c, input int tgt, input logic d);
      latch[c] = 1'b1;
      div_target[c*DW +: DW] = 32'(tgt);
      dir[c] = d;
      step();
      latch = '0;
   endtask

   initial begin
      int n;
      int p;
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; latch = '0; div_target = '0; dir = '0; run = '0; ramp_step = 16'd30;
      step();
      step();
      chk("reset_div0", o_div[31:0], 32'd100);
      chk("reset_run", 32'(o_running), 32'd0);
      rst_n = 1'b1;

      // Soft start of ch0 to 40, then cruise period
      do_latch(0, 40, 1'b0);
      run[0] = 1'b1;
      wait_bit("start_running", 0, 0, 1'b1, 5);
      wait_bit("start_at_target", 1, 0, 1'b1, 50);
      chk("start_div40", o_div[31:0], 32'd40);
      chk("ch1_idle_phase", 32'(o_phase[5:3]), 32'd0);
      wait_bit("cruise_tick_a", 2, 0, 1'b1, 100);
      n = 0;
      do begin step(); n++; end while (o_tick[0] !== 1'b1 && n < 200);
      chk("cruise_tick_period", 32'(n), 32'd40);

      // Reverse on ch1; a direction latched while spinning must not apply
      do_latch(1, 10, 1'b1);
      run[1] = 1'b1;
      wait_bit("rev_tick1", 2, 1, 1'b1, 400);
      chk("rev_phase5", 32'(o_phase[5:3]), 32'd5);
      wait_bit("rev_tick2", 2, 1, 1'b1, 400);
      chk("rev_phase4", 32'(o_phase[5:3]), 32'd4);
      wait_bit("rev_tick3", 2, 1, 1'b1, 400);
      chk("rev_phase3", 32'(o_phase[5:3]), 32'd3);
      do_latch(1, 10, 1'b0);
      wait_bit("rev_tick4", 2, 1, 1'b1, 400);
      chk("rev_phase2", 32'(o_phase[5:3]), 32'd2);
      wait_bit("rev_tick5", 2, 1, 1'b1, 400);
      chk("rev_phase1", 32'(o_phase[5:3]), 32'd1);
      run[1] = 1'b0;
      wait_bit("rev_stop_idle", 0, 1, 1'b0, 1000);
      p = m_phase[1];
      run[1] = 1'b1;
      wait_bit("fwd_restart_tick", 2, 1, 1'b1, 400);
      chk("fwd_restart_phase", 32'(o_phase[5:3]), 32'((p + 1) % 6));

      // Soft stop of ch0 from cruise; phase must freeze
      run[0] = 1'b0;
      wait_bit("stop_idle", 0, 0, 1'b0, 100);
      chk("stop_div100", o_div[31:0], 32'd100);
      p = m_phase[0];
      for (int k = 0; k < 50; k++) step();
      chk("stop_phase_frozen", 32'(o_phase[2:0]), 32'(p));

      // Clamp low, zero target as stop, clamp high
      do_latch(0, 5, 1'b0);
      run[0] = 1'b1;
      wait_bit("clamp_low_at", 1, 0, 1'b1, 300);
      chk("clamp_low_div", o_div[31:0], 32'd10);
      do_latch(0, 0, 1'b0);
      wait_bit("zero_stop_idle", 0, 0, 1'b0, 300);
      chk("zero_stop_div", o_div[31:0], 32'd100);
      do_latch(0, 500, 1'b0);
      wait_bit("clamp_high_at", 1, 0, 1'b1, 50);
      chk("clamp_high_div", o_div[31:0], 32'd100);
      run[0] = 1'b0;
      wait_bit("clamp_high_idle", 0, 0, 1'b0, 50);

      // Zero step jumps; large step saturates on target
      ramp_step = 16'd0;
      do_latch(0, 40, 1'b0);
      run[0] = 1'b1;
      wait_div_change("step0_change", 0, 50);
      chk("step0_jump", o_div[31:0], 32'd40);
      run[0] = 1'b0;
      wait_bit("step0_idle", 0, 0, 1'b0, 50);
      ramp_step = 16'd50;
      do_latch(0, 70, 1'b0);
      run[0] = 1'b1;
      wait_div_change("step50_change", 0, 50);
      chk("step50_land", o_div[31:0], 32'd70);
      run[0] = 1'b0;
      wait_bit("step50_idle", 0, 0, 1'b0, 50);

      // Reset in the middle of ramping on both channels
      ramp_step = 16'd30;
      latch = 2'b11;
      div_target = {32'd70, 32'd10};
      dir = '0;
      step();
      latch = '0;
      run = 2'b11;
      for (int k = 0; k < 3; k++) step();
      chk("pre_reset_running", 32'(o_running), 32'd3);
      rst_n = 1'b0;
      step();
      chk("rst_phase", 32'(o_phase), 32'd0);
      chk("rst_div0", o_div[31:0], 32'd100);
      chk("rst_div1", o_div[63:32], 32'd100);
      chk("rst_flags", 32'({o_running, o_at, o_tick}), 32'd0);
      rst_n = 1'b1;
      run = '0;

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         latch = '0;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 15) == 0) begin
               latch[c] = 1'b1;
               div_target[c*DW +: DW] = 32'($urandom_range(0, 120));
               dir[c] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) run[c] = ~run[c];
         end
         if ($urandom_range(0, 99) == 0) ramp_step = 16'($urandom_range(0, 60));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
